pcpi_systolic_mac_array: RTL and testbench
==========================================

// Module: pcpi_systolic_mac_array
// PURPOSE
//  Parametrised NxN output-stationary systolic multiply-accumulate coprocessor on the PicoRV32 PCPI bus.
//  Computes C = A*B + bias for signed DW-bit operands. Results can be read back two ways:
//   - full-precision elements, saturated to 32 bits;
//   - a packed threshold mask (C >= threshold).
//  Sits beside the CPU core as the next-generation custom-0 (opcode 7'b0001011) accelerator.
// PARAMETERS
//  N    3   array dimension; legal 2..5 (N*N <= 32 so the mask fits one word)
//  DW   16  signed operand/bias width
//  ACCW 2*DW+$clog2(N)+1  signed accumulator width; never overflows
// PORTS
//  clk         in   1   single clock, rising edge
//  resetn      in   1   asynchronous active-low reset
//  pcpi_valid  in   1   instruction offered; held high by CPU until pcpi_ready
//  pcpi_insn   in   32  instruction word; opcode [6:0], funct3 [14:12]
//  pcpi_rs1    in   32  operand 1 (flat address / element index)
//  pcpi_rs2    in   32  operand 2 (write data)
//  pcpi_wr     out  1   rd writeback enable, valid with pcpi_ready
//  pcpi_rd     out  32  rd data, valid with pcpi_ready
//  pcpi_wait   out  1   coprocessor busy; CPU must keep stalling
//  pcpi_ready  out  1   one-cycle completion pulse
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; A, B, bias, accumulators and mask all 0; threshold 0.
//  Decode: accepted only when pcpi_valid && opcode==0001011 && funct3 in {000,001,010,101,111} && FSM==IDLE.
//   Any other funct3 gets no response (no ready, no wait); the CPU timeout traps it.
//  WRITE (000): rs1[7:0] = flat address: A at 0..N*N-1, B at N*N..2N*N-1, bias at 2N*N..3N*N-1
//   (row-major); 3N*N = threshold (full 32-bit signed rs2). Operands take rs2[DW-1:0].
//   Out-of-range address is ignored and still completes.
//   Response: ready=1, wr=0 one cycle after accept.
//  READ_C (001): rs1 = row-major index. rd = C[idx] saturated to [-2^31, 2^31-1]. ready=1, wr=1 next cycle.
//   Index >= N*N returns 0.
//  READ_MASK (010): rd bit k = (C[k] >= threshold), signed compare at ACCW; bits >= N*N are 0. ready=1, wr=1.
//  CLEAR (101): zeroes A, B, bias, C and mask; threshold kept. ready=1, wr=0.
//  START (111): FSM IDLE -> RUN; pcpi_wait=1 from the cycle after accept.
//   RUN cycle 0 seeds each PE accumulator with sign-extended bias.
//   Row r of A and column c of B enter skewed by r/c cycles; zeros outside the valid window.
//   RUN lasts exactly 3N-2 cycles (7 for N=3), then CAPTURE (1 cycle):
//    latch C, compute mask, wait=0, ready=1, wr=1, rd = mask. FSM -> IDLE.
//   Total START latency: 3N cycles accept->ready.
//  pcpi_ready is always a single-cycle pulse. The cycle after any ready pulse ignores pcpi_valid
//   (guard flop), so an instruction whose valid is still high is not executed twice.
//  Operands persist across STARTs; re-START with unchanged operands reproduces identical C.
//  Reset mid-RUN: outputs drop to 0 immediately (async); state and data return to reset values;
//   the interrupted instruction is never acknowledged.
//  No instruction is accepted while in RUN or CAPTURE (only reachable if the CPU misbehaves); such requests are ignored.
// STRUCTURE
//  Package pcpi_mac_pkg holds:
//   - opcode/funct3 constants;
//   - FSM state enum {IDLE, RUN, CAPTURE};
//   - address-map base helpers as functions of N.
//  Sub-module sys_mac_pe (DW, ACCW): registered a/b pass-through plus accumulator,
//   with a seed input that loads bias on RUN cycle 0. The top generates an NxN grid,
//   plus edge skew muxes driven by the run counter.
//  The run counter is $clog2(3N) bits wide. The clock is never gated; PE enables come from FSM==RUN.
// TESTING
//  1. N=3: A=I, B=1..9, bias=0, START -> ready exactly 9 cycles after accept; READ_C idx4 returns 5.
//  2. Threshold=5 (write addr 27), READ_MASK -> 0x000001F0; threshold=-1 -> 0x000001FF.
//  3. A=B=bias all 0x7FFF -> READ_C idx0 returns 0x7FFFFFFF; all 0x8000 with B=0x7FFF -> 0x80000000.
//  4. bias=-3 everywhere, A=0, START -> every READ_C returns 0xFFFFFFFD.
//  5. resetn low on RUN cycle 3 -> wait/ready/wr go 0 at once; after release READ_MASK returns 0.
//  6. pcpi_valid held 2 cycles past ready on a WRITE -> exactly one ready pulse.
//     funct3=011 -> no ready for 20 cycles.

Source files
------------

// File: rtl/pcpi_systolic_mac_array_pkg.sv
// Shared constants, FSM state type and address-map helpers for the
// PCPI systolic multiply-accumulate coprocessor.
package pcpi_mac_pkg;

    localparam logic [6:0] OPC_CUSTOM0   = 7'b0001011;

    localparam logic [2:0] F3_WRITE      = 3'b000;
    localparam logic [2:0] F3_READ_C     = 3'b001;
    localparam logic [2:0] F3_READ_MASK  = 3'b010;
    localparam logic [2:0] F3_CLEAR      = 3'b101;
    localparam logic [2:0] F3_START      = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } mac_state_e;

    // Flat address map: A at 0, then B, then bias, then the threshold word.
    function automatic int b_base(input int n);
        return n * n;
    endfunction

    function automatic int bias_base(input int n);
        return 2 * n * n;
    endfunction

    function automatic int thr_addr(input int n);
        return 3 * n * n;
    endfunction

endpackage

// File: rtl/pcpi_systolic_mac_array_if.sv
// PCPI bus bundle between the CPU core (master) and the coprocessor (slave).
interface pcpi_systolic_mac_array_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

endinterface

// File: rtl/pcpi_systolic_mac_array_pe.sv
// One processing element of the output-stationary grid: forwards its a/b
// operands one cycle later to the right/lower neighbour and accumulates
// a*b locally. The seed cycle starts the sum from the bias instead of
// the previous accumulator.
module sys_mac_pe #(
    parameter int DW   = 16,
    parameter int ACCW = 35
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
    input  logic                   seed,
    input  logic                   clr,
    input  logic signed [DW-1:0]   a_in,
    input  logic signed [DW-1:0]   b_in,
    input  logic signed [DW-1:0]   bias,
    output logic signed [DW-1:0]   a_out,
    output logic signed [DW-1:0]   b_out,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;

    assign prod = (2*DW)'(a_in) * (2*DW)'(b_in);

    // Operand forwarding (flushed to zero outside RUN) and accumulation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= en ? a_in : '0;
            b_out <= en ? b_in : '0;
            if (en) begin
                acc <= (seed ? ACCW'(bias) : acc) + ACCW'(prod);
            end
        end
    end

endmodule

// File: rtl/pcpi_systolic_mac_array.sv
// NxN output-stationary systolic MAC coprocessor on the PicoRV32 PCPI bus.
// Computes C = A*B + bias; C is read back saturated to 32 bits or as a
// packed (C >= threshold) mask.
module pcpi_systolic_mac_array
    import pcpi_mac_pkg::*;
#(
    parameter int N    = 3,
    parameter int DW   = 16,
    parameter int ACCW = 2*DW + $clog2(N) + 1
) (
    input logic                        clk,
    input logic                        resetn,
    pcpi_systolic_mac_array_if.slave   bus
);

    localparam int NN        = N * N;
    localparam int CNTW      = $clog2(3 * N);
    localparam int B_BASE    = b_base(N);
    localparam int BIAS_BASE = bias_base(N);
    localparam int THR_ADDR  = thr_addr(N);
    localparam logic [CNTW-1:0] RUN_LAST = CNTW'(3 * N - 3);

    function automatic logic [31:0] sat32(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] hi;
        logic signed [ACCW-1:0] lo;
        hi = ACCW'($signed(33'h0_7FFF_FFFF));
        lo = ACCW'($signed(33'h1_8000_0000));
        if (v > hi)      return 32'h7FFF_FFFF;
        else if (v < lo) return 32'h8000_0000;
        else             return v[31:0];
    endfunction

    mac_state_e              state_q, state_d;
    logic [CNTW-1:0]         run_cnt;
    logic                    guard;
    logic                    ready_q, wr_q, wait_q;
    logic [31:0]             rd_q;

    logic signed [DW-1:0]    a_mem [NN];
    logic signed [DW-1:0]    b_mem [NN];
    logic signed [DW-1:0]    bias_mem [NN];
    logic signed [31:0]      thr;
    logic signed [ACCW-1:0]  c_lat [NN];
    logic signed [ACCW-1:0]  acc_q [NN];
    logic                    c_vld;

    logic [2:0]              f3;
    logic                    f3_ok, accept, run_en, seed, clr;
    logic [7:0]              addr;
    logic signed [ACCW-1:0]  thr_ext;
    logic [31:0]             mask_lat, mask_acc, rdc;
    logic signed [DW-1:0]    a_edge [N];
    logic signed [DW-1:0]    b_edge [N];
    logic signed [DW-1:0]    a_h [N][N+1];
    logic signed [DW-1:0]    b_v [N+1][N];
    logic [N-1:0]            unused_a_tail, unused_b_tail;
    logic                    unused_insn;

    assign f3      = bus.pcpi_insn[14:12];
    assign f3_ok   = f3 inside {F3_WRITE, F3_READ_C, F3_READ_MASK, F3_CLEAR, F3_START};
    // ready_q and guard keep a still-asserted valid from re-executing.
    assign accept  = bus.pcpi_valid && (bus.pcpi_insn[6:0] == OPC_CUSTOM0) && f3_ok &&
                     (state_q == ST_IDLE) && !ready_q && !guard;
    assign addr    = bus.pcpi_rs1[7:0];
    assign run_en  = (state_q == ST_RUN);
    assign seed    = run_en && (run_cnt == '0);
    assign clr     = accept && (f3 == F3_CLEAR);
    assign thr_ext = ACCW'(thr);
    assign unused_insn = ^{bus.pcpi_insn[31:15], bus.pcpi_insn[11:7]};

    assign bus.pcpi_ready = ready_q;
    assign bus.pcpi_wr    = wr_q;
    assign bus.pcpi_rd    = rd_q;
    assign bus.pcpi_wait  = wait_q;

    // Skewed edge feed: row r of A / column c of B enter r / c cycles late.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_edge[r] = '0;
            b_edge[r] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(run_cnt) == r + k) begin
                    a_edge[r] = a_mem[r*N + k];
                    b_edge[r] = b_mem[k*N + r];
                end
            end
        end
    end

    genvar gr, gc;
    generate
        for (gr = 0; gr < N; gr++) begin : g_row
            assign a_h[gr][0]        = a_edge[gr];
            assign b_v[0][gr]        = b_edge[gr];
            assign unused_a_tail[gr] = ^a_h[gr][N];
            assign unused_b_tail[gr] = ^b_v[N][gr];
            for (gc = 0; gc < N; gc++) begin : g_col
                sys_mac_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
                    .clk    (clk),
                    .resetn (resetn),
                    .en     (run_en),
                    .seed   (seed),
                    .clr    (clr),
                    .a_in   (a_h[gr][gc]),
                    .b_in   (b_v[gr][gc]),
                    .bias   (bias_mem[gr*N + gc]),
                    .a_out  (a_h[gr][gc+1]),
                    .b_out  (b_v[gr+1][gc]),
                    .acc    (acc_q[gr*N + gc])
                );
            end
        end
    endgenerate

    // Threshold masks from latched C (readback) and live accumulators (capture).
    always_comb begin
        mask_lat = '0;
        mask_acc = '0;
        rdc      = '0;
        for (int k = 0; k < NN; k++) begin
            mask_lat[k] = c_vld && (c_lat[k] >= thr_ext);
            mask_acc[k] = (acc_q[k] >= thr_ext);
            if (bus.pcpi_rs1 == 32'(k)) rdc = sat32(c_lat[k]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: IDLE -> RUN (3N-2 cycles) -> CAPTURE (1 cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept && (f3 == F3_START)) state_d = ST_RUN;
            ST_RUN:     if (run_cnt == RUN_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Run counter, held at zero outside RUN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     run_cnt <= '0;
        else if (run_en) run_cnt <= run_cnt + 1'b1;
        else             run_cnt <= '0;
    end

    // Guard stays set from a ready pulse until the CPU drops valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) guard <= 1'b0;
        else         guard <= ready_q ? 1'b1 : (guard && bus.pcpi_valid);
    end

    // Bus response: single-cycle ready pulse with rd/wr, wait during a run.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            wait_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
            if (accept) begin
                unique case (f3)
                    F3_READ_C:    begin ready_q <= 1'b1; wr_q <= 1'b1; rd_q <= rdc;      end
                    F3_READ_MASK: begin ready_q <= 1'b1; wr_q <= 1'b1; rd_q <= mask_lat; end
                    F3_START:     wait_q  <= 1'b1;
                    default:      ready_q <= 1'b1;
                endcase
            end else if (state_q == ST_CAPTURE) begin
                wait_q  <= 1'b0;
                ready_q <= 1'b1;
                wr_q    <= 1'b1;
                rd_q    <= mask_acc;
            end
        end
    end

    // Operand store, threshold and latched results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NN; k++) begin
                a_mem[k] <= '0; b_mem[k] <= '0; bias_mem[k] <= '0; c_lat[k] <= '0;
            end
            thr   <= '0;
            c_vld <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < NN; k++) begin
                a_mem[k] <= '0; b_mem[k] <= '0; bias_mem[k] <= '0; c_lat[k] <= '0;
            end
            c_vld <= 1'b0;
        end else if (accept && (f3 == F3_WRITE)) begin
            for (int k = 0; k < NN; k++) begin
                if (addr == 8'(k))             a_mem[k]    <= bus.pcpi_rs2[DW-1:0];
                if (addr == 8'(B_BASE + k))    b_mem[k]    <= bus.pcpi_rs2[DW-1:0];
                if (addr == 8'(BIAS_BASE + k)) bias_mem[k] <= bus.pcpi_rs2[DW-1:0];
            end
            if (addr == 8'(THR_ADDR)) thr <= bus.pcpi_rs2;
        end else if (state_q == ST_CAPTURE) begin
            for (int k = 0; k < NN; k++) c_lat[k] <= acc_q[k];
            c_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcpi_systolic_mac_array.sv
// Directed bench for the PCPI systolic MAC coprocessor (N=3, DW=16).
module tb_pcpi_systolic_mac_array;
    import pcpi_mac_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] r_rd;
    logic        r_wr;
    int          r_lat;
    logic        r_wait1;
    logic        r_wait_rdy;
    int          pulses;

    pcpi_systolic_mac_array_if bus();

    pcpi_systolic_mac_array #(.N(3), .DW(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_insn(input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input string tag);
        logic got;
        got        = 1'b0;
        r_lat      = 0;
        r_rd       = '0;
        r_wr       = 1'b0;
        r_wait1    = 1'b0;
        r_wait_rdy = 1'b1;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = {17'd0, f3, 5'd1, OPC_CUSTOM0};
        bus.pcpi_rs1   = rs1;
        bus.pcpi_rs2   = rs2;
        while (!got && r_lat < 64) begin
            @(posedge clk);
            #1;
            r_lat++;
            if (r_lat == 1) r_wait1 = bus.pcpi_wait;
            if (bus.pcpi_ready) begin
                got        = 1'b1;
                r_rd       = bus.pcpi_rd;
                r_wr       = bus.pcpi_wr;
                r_wait_rdy = bus.pcpi_wait;
            end
        end
        bus.pcpi_valid = 1'b0;
        check({tag, " ready_seen"}, 32'(got), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wr_word(input int a, input logic [31:0] d);
        do_insn(F3_WRITE, 32'(a), d, "write");
    endtask

    task automatic rd_c(input int idx, input logic [31:0] exp, input string tag);
        do_insn(F3_READ_C, 32'(idx), 32'd0, tag);
        check(tag, r_rd, exp);
    endtask

    task automatic start_run(input logic [31:0] exp_mask, input string tag);
        do_insn(F3_START, 32'd0, 32'd0, tag);
        check({tag, " latency"}, 32'(r_lat), 32'd9);
        check({tag, " wait_after_accept"}, 32'(r_wait1), 32'd1);
        check({tag, " wait_at_ready"}, 32'(r_wait_rdy), 32'd0);
        check({tag, " wr"}, 32'(r_wr), 32'd1);
        check({tag, " mask"}, r_rd, exp_mask);
    endtask

    initial begin
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;
        resetn         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.pcpi_ready), 32'd0);
        check("reset wait",  32'(bus.pcpi_wait),  32'd0);
        check("reset wr",    32'(bus.pcpi_wr),    32'd0);
        check("reset rd",    bus.pcpi_rd,         32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // A = identity, B = 1..9, bias = 0 -> C = B
        wr_word(0, 32'd1);
        check("write latency", 32'(r_lat), 32'd1);
        check("write wr", 32'(r_wr), 32'd0);
        wr_word(4, 32'd1);
        wr_word(8, 32'd1);
        for (int k = 0; k < 9; k++) wr_word(9 + k, 32'(k + 1));
        start_run(32'h0000_01FF, "ident start");
        rd_c(4, 32'd5, "ident c4");
        check("read_c wr", 32'(r_wr), 32'd1);
        rd_c(0, 32'd1, "ident c0");
        rd_c(8, 32'd9, "ident c8");
        rd_c(9, 32'd0, "c idx out of range");

        // Threshold mask
        wr_word(27, 32'd5);
        do_insn(F3_READ_MASK, 32'd0, 32'd0, "mask thr5");
        check("mask thr5", r_rd, 32'h0000_01F0);
        check("mask wr", 32'(r_wr), 32'd1);
        wr_word(27, 32'hFFFF_FFFF);
        do_insn(F3_READ_MASK, 32'd0, 32'd0, "mask thr-1");
        check("mask thr-1", r_rd, 32'h0000_01FF);
        wr_word(40, 32'd77);
        check("oob write latency", 32'(r_lat), 32'd1);
        rd_c(4, 32'd5, "c4 after oob write");

        // A = B = [1..9], bias[0] = -100: C = A*B + bias
        for (int k = 0; k < 9; k++) wr_word(k, 32'(k + 1));
        wr_word(18, 32'hFFFF_FF9C);
        start_run(32'h0000_01FE, "matmul start");
        rd_c(0, 32'hFFFF_FFBA, "matmul c0");
        rd_c(5, 32'd96, "matmul c5");
        rd_c(7, 32'd126, "matmul c7");
        start_run(32'h0000_01FE, "matmul restart");
        rd_c(8, 32'd150, "restart c8");
        rd_c(7, 32'd126, "restart c7");

        // Saturation
        for (int k = 0; k < 27; k++) wr_word(k, 32'h0000_7FFF);
        start_run(32'h0000_01FF, "sat_hi start");
        rd_c(0, 32'h7FFF_FFFF, "sat_hi c0");
        for (int k = 0; k < 9; k++) begin
            wr_word(k, 32'h0000_8000);
            wr_word(18 + k, 32'h0000_8000);
        end
        start_run(32'h0000_0000, "sat_lo start");
        rd_c(0, 32'h8000_0000, "sat_lo c0");
        rd_c(8, 32'h8000_0000, "sat_lo c8");

        // CLEAR, then bias = -3 everywhere with A = 0
        do_insn(F3_CLEAR, 32'd0, 32'd0, "clear");
        check("clear wr", 32'(r_wr), 32'd0);
        do_insn(F3_READ_MASK, 32'd0, 32'd0, "mask after clear");
        check("mask after clear", r_rd, 32'd0);
        rd_c(0, 32'd0, "c0 after clear");
        for (int k = 0; k < 9; k++) wr_word(18 + k, 32'hFFFF_FFFD);
        start_run(32'h0000_0000, "bias start");
        for (int k = 0; k < 9; k++) rd_c(k, 32'hFFFF_FFFD, "bias c");

        // Reset on RUN cycle 3
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = {17'd0, F3_START, 5'd1, OPC_CUSTOM0};
        repeat (4) @(posedge clk);
        #1;
        check("mid-run wait", 32'(bus.pcpi_wait), 32'd1);
        resetn = 1'b0;
        #1;
        check("async reset wait",  32'(bus.pcpi_wait),  32'd0);
        check("async reset ready", 32'(bus.pcpi_ready), 32'd0);
        check("async reset wr",    32'(bus.pcpi_wr),    32'd0);
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.pcpi_ready || bus.pcpi_wait) pulses++;
        end
        check("no ack after reset", 32'(pulses), 32'd0);
        do_insn(F3_READ_MASK, 32'd0, 32'd0, "mask after reset");
        check("mask after reset", r_rd, 32'd0);

        // Valid held past ready: exactly one pulse
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = {17'd0, F3_WRITE, 5'd1, OPC_CUSTOM0};
        bus.pcpi_rs1   = 32'd0;
        bus.pcpi_rs2   = 32'd7;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.pcpi_ready) pulses++;
            if (i == 3) bus.pcpi_valid = 1'b0;
        end
        check("held valid pulses", 32'(pulses), 32'd1);

        // Unsupported funct3 gets no response
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = {17'd0, 3'b011, 5'd1, OPC_CUSTOM0};
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.pcpi_ready || bus.pcpi_wait) pulses++;
        end
        bus.pcpi_valid = 1'b0;
        check("funct3 011 response", 32'(pulses), 32'd0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
